// File: rtl/detect_sched_pkg.sv
// Shared types and constants for the detect/count/down-count session scheduler.
package detect_sched_pkg;

  localparam int STATE_W            = 3;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_DETECT = 3'd2,
    S_COUNT  = 3'd3,
    S_LOAD   = 3'd4,
    S_DOWN   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/detect_sched_if.sv
// Session handshake between two requesters and the scheduler.
interface detect_sched_if;
  logic [1:0] req;
  logic [1:0] grant;
  logic       ready;
  logic       done;
  logic       err;

  modport master (output req, input grant, ready, done, err);
  modport slave  (input req, output grant, ready, done, err);
endinterface

// File: rtl/detect_sched_rr_arbiter_2.sv
// Two-way round-robin pick; purely combinational, the scheduler registers the result.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/detect_sched.sv
// Session scheduler sharing one detector/counter/down-counter datapath between two requesters.
// Optional DETECT-phase timeout is built when DETECT_SCHED_TIMEOUT_EN is defined.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   S_IDLE   | free, ready=1, arbitrate on any req
//   S_INIT   | preset counter to 8, start detector (one cycle)
//   S_DETECT | wait for pattern (optionally bounded by timeout)
//   S_COUNT  | run 8-count until carry
//   S_LOAD   | load and start down-counter (one cycle)
//   S_DOWN   | run down-counter until carry
//   S_DONE   | done pulse, release grant, advance rr_ptr
module detect_sched
  import detect_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  detect_sched_if.slave  bus,
  input  logic           w_detector,
  input  logic           co_counter,
  input  logic           co_downcounter,
  output logic           set_8,
  output logic           en_detector,
  output logic           en_counter,
  output logic           load_downcounter,
  output logic           en_downcounter
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("detect_sched: TIMEOUT_CYCLES must be within 2..255");
  end

  state_t     state;
  logic [1:0] grant_q;
  logic       ready_q;
  logic       done_q;
  logic       rr_ptr;
  logic [1:0] arb_grant;

  rr_arbiter_2 u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant)
  );

`ifdef DETECT_SCHED_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;
  logic       err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.grant = grant_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      grant_q <= 2'b00;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rr_ptr  <= 1'b0;
`ifdef DETECT_SCHED_TIMEOUT_EN
      tmo_cnt <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef DETECT_SCHED_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (bus.req != 2'b00) begin
            grant_q <= arb_grant;
            ready_q <= 1'b0;
            state   <= S_INIT;
          end
        end
        S_INIT: begin
`ifdef DETECT_SCHED_TIMEOUT_EN
          tmo_cnt <= 8'd0;
`endif
          state <= S_DETECT;
        end
        S_DETECT: begin
`ifdef DETECT_SCHED_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 8'd1;
`endif
          // A pattern seen on the last allowed cycle still wins over the timeout.
          if (w_detector) begin
            state <= S_COUNT;
          end
`ifdef DETECT_SCHED_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end
`endif
        end
        S_COUNT: begin
          if (co_counter) state <= S_LOAD;
        end
        S_LOAD: begin
          state <= S_DOWN;
        end
        S_DOWN: begin
          if (co_downcounter) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          rr_ptr  <= grant_q[0];
          grant_q <= 2'b00;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          grant_q <= 2'b00;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    set_8            = 1'b0;
    en_detector      = 1'b0;
    en_counter       = 1'b0;
    load_downcounter = 1'b0;
    en_downcounter   = 1'b0;
    case (state)
      S_INIT: begin
        set_8       = 1'b1;
        en_detector = 1'b1;
      end
      S_DETECT: begin
        en_detector = ~w_detector;
        en_counter  = w_detector;
      end
      S_COUNT: en_counter = 1'b1;
      S_LOAD: begin
        load_downcounter = 1'b1;
        en_downcounter   = 1'b1;
      end
      S_DOWN:  en_downcounter = ~co_downcounter;
      default: ;
    endcase
  end

endmodule
